// File: rtl/i2s_slave_xcvr_pkg.sv
// Shared types and constants for the I2S slave transceiver.
// Holds the RX state encoding, the channel encoding and the two framing delays.
package i2s_slave_xcvr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSkip,
        StShift,
        StWait
    } rx_state_e;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam int unsigned I2S_DELAY = 1;
    localparam int unsigned LJ_DELAY  = 0;

endpackage

// File: rtl/i2s_slave_xcvr_edge_det.sv
// Registers BCLK and LRCLK once and flags their edges.
// The edge flags are high for exactly one audio_clk cycle after the input changes.
module i2s_edge_det
    import i2s_slave_xcvr_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bclk,
    input  logic lrclk,
    output logic rise,
    output logic fall,
    output logic lr_edge
);

    logic bclk_d;
    logic lrclk_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_d  <= 1'b0;
            lrclk_d <= 1'b0;
        end else begin
            bclk_d  <= bclk;
            lrclk_d <= lrclk;
        end
    end

    assign rise    = bclk & ~bclk_d;
    assign fall    = ~bclk & bclk_d;
    assign lr_edge = lrclk ^ lrclk_d;

endmodule

// File: rtl/i2s_slave_xcvr.sv
// Codec-side I2S / left-justified transceiver running on audio_clk.
// Deserialises DAC_SDATA into left/right playback words and serialises record words on ADC_SDATA.
module i2s_slave_xcvr
    import i2s_slave_xcvr_pkg::*;
#(
    parameter int unsigned N     = 24,
    parameter int unsigned DELAY = 1,
    parameter int unsigned CNTW  = 6
) (
    input  logic         audio_clk,
    input  logic         reset,
    input  logic         BCLK,
    input  logic         LRCLK,
    input  logic         DAC_SDATA,
    input  logic [N-1:0] LeftAdcData,
    input  logic [N-1:0] RightAdcData,
    output logic         ADC_SDATA,
    output logic [N-1:0] LeftDacData,
    output logic [N-1:0] RightDacData,
    output logic         DacValid,
    output logic         DacIsRight,
    output logic         FrameErr,
    output logic         Locked
);

    localparam logic [CNTW-1:0] SKIP_END = CNTW'(DELAY);
    localparam logic [CNTW-1:0] WORD_END = CNTW'(DELAY + N);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    logic rise;
    logic fall;
    logic lr_edge;

    i2s_edge_det u_edge_det (
        .clk     (audio_clk),
        .reset   (reset),
        .bclk    (BCLK),
        .lrclk   (LRCLK),
        .rise    (rise),
        .fall    (fall),
        .lr_edge (lr_edge)
    );

    // ---------------- RX ----------------
    rx_state_e       state;
    logic [CNTW-1:0] rise_cnt;
    logic [CNTW-1:0] rise_cnt_inc;
    logic [N-1:0]    rx_sr;
    logic            rx_ch;
    logic            wr_pend;

    always_comb begin
        rise_cnt_inc = rise_cnt;
        if (rise_cnt != CNT_MAX) begin
            rise_cnt_inc = rise_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge audio_clk) begin
        if (reset) begin
            state        <= StIdle;
            rise_cnt     <= '0;
            rx_sr        <= '0;
            rx_ch        <= CH_LEFT;
            wr_pend      <= 1'b0;
            LeftDacData  <= '0;
            RightDacData <= '0;
            DacValid     <= 1'b0;
            DacIsRight   <= 1'b0;
            FrameErr     <= 1'b0;
            Locked       <= 1'b0;
        end else begin
            DacValid <= 1'b0;
            FrameErr <= 1'b0;

            // Completion write uses the pre-edge rx_sr/rx_ch even if a new half-frame starts now.
            if (wr_pend) begin
                wr_pend    <= 1'b0;
                DacValid   <= 1'b1;
                DacIsRight <= rx_ch;
                if (rx_ch == CH_RIGHT) begin
                    RightDacData <= rx_sr;
                end else begin
                    LeftDacData <= rx_sr;
                end
            end

            if (lr_edge) begin
                if (state == StSkip || state == StShift) begin
                    FrameErr <= 1'b1;
                end
                Locked   <= 1'b1;
                rise_cnt <= '0;
                rx_sr    <= '0;
                rx_ch    <= LRCLK;
                if (DELAY == 0) begin
                    state <= StShift;
                end else begin
                    state <= StSkip;
                end
            end else if (rise) begin
                rise_cnt <= rise_cnt_inc;
                case (state)
                    StSkip: begin
                        if (rise_cnt_inc == SKIP_END) begin
                            state <= StShift;
                        end
                    end
                    StShift: begin
                        rx_sr <= {rx_sr[N-2:0], DAC_SDATA};
                        if (rise_cnt_inc == WORD_END) begin
                            state   <= StWait;
                            wr_pend <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- TX ----------------
    logic [N-1:0]    tx_sr;
    logic [N-1:0]    tx_word;
    logic [CNTW-1:0] fall_cnt;
    logic [CNTW-1:0] fall_cnt_inc;

    always_comb begin
        tx_word      = (LRCLK == CH_RIGHT) ? RightAdcData : LeftAdcData;
        fall_cnt_inc = fall_cnt;
        if (fall_cnt != CNT_MAX) begin
            fall_cnt_inc = fall_cnt + CNT_ONE;
        end
    end

    // The lrEdge cycle is fall index 0, so the counter resumes at 1 on the next fall.
    always_ff @(posedge audio_clk) begin
        if (reset) begin
            tx_sr     <= '0;
            fall_cnt  <= '0;
            ADC_SDATA <= 1'b0;
        end else if (lr_edge) begin
            fall_cnt <= CNT_ONE;
            if (DELAY == 0) begin
                ADC_SDATA <= tx_word[N-1];
                tx_sr     <= {tx_word[N-2:0], 1'b0};
            end else begin
                ADC_SDATA <= 1'b0;
                tx_sr     <= tx_word;
            end
        end else if (fall && Locked) begin
            fall_cnt <= fall_cnt_inc;
            if (fall_cnt >= SKIP_END && fall_cnt < WORD_END) begin
                ADC_SDATA <= tx_sr[N-1];
                tx_sr     <= {tx_sr[N-2:0], 1'b0};
            end else begin
                ADC_SDATA <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_slave_xcvr.sv
// Bench for i2s_slave_xcvr: an I2S and a left-justified instance share one bus master.
// Expected playback events go into per-instance queues that monitors pop as the DUTs report.
module tb_i2s_slave_xcvr;
    import i2s_slave_xcvr_pkg::*;

    localparam int N = 24;

    typedef struct packed {
        logic         is_err;
        logic         right;
        logic [N-1:0] data;
    } ev_t;

    logic         audio_clk = 1'b0;
    logic         reset     = 1'b1;
    logic         BCLK      = 1'b0;
    logic         LRCLK     = 1'b0;
    logic         dac1      = 1'b0;
    logic         dac0      = 1'b0;
    logic [N-1:0] l_adc1    = 24'h800001;
    logic [N-1:0] r_adc1    = 24'h7FFFFF;
    logic [N-1:0] adc0      = 24'h123456;

    logic         adc_sd1, valid1, isr1, ferr1, lock1;
    logic [N-1:0] l_dac1, r_dac1;
    logic         adc_sd0, valid0, isr0, ferr0, lock0;
    logic [N-1:0] l_dac0, r_dac0;

    ev_t          q1[$];
    ev_t          q0[$];
    ev_t          e1, e0;
    logic [N-1:0] last_left = '0;
    int           vectors = 0;
    int           miscompares = 0;

    always #5 audio_clk = ~audio_clk;

    i2s_slave_xcvr #(.N(N), .DELAY(I2S_DELAY), .CNTW(6)) dut1 (
        .audio_clk    (audio_clk),
        .reset        (reset),
        .BCLK         (BCLK),
        .LRCLK        (LRCLK),
        .DAC_SDATA    (dac1),
        .LeftAdcData  (l_adc1),
        .RightAdcData (r_adc1),
        .ADC_SDATA    (adc_sd1),
        .LeftDacData  (l_dac1),
        .RightDacData (r_dac1),
        .DacValid     (valid1),
        .DacIsRight   (isr1),
        .FrameErr     (ferr1),
        .Locked       (lock1)
    );

    i2s_slave_xcvr #(.N(N), .DELAY(LJ_DELAY), .CNTW(6)) dut0 (
        .audio_clk    (audio_clk),
        .reset        (reset),
        .BCLK         (BCLK),
        .LRCLK        (LRCLK),
        .DAC_SDATA    (dac0),
        .LeftAdcData  (adc0),
        .RightAdcData (adc0),
        .ADC_SDATA    (adc_sd0),
        .LeftDacData  (l_dac0),
        .RightDacData (r_dac0),
        .DacValid     (valid0),
        .DacIsRight   (isr0),
        .FrameErr     (ferr0),
        .Locked       (lock0)
    );

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic slot_bit(input logic [N-1:0] w, input int s);
        if (s >= 0 && s < N) return w[N-1-s];
        return 1'b0;
    endfunction

    task automatic expect_word(input logic right, input logic [N-1:0] w);
        ev_t e;
        e.is_err = 1'b0;
        e.right  = right;
        e.data   = w;
        q1.push_back(e);
        q0.push_back(e);
        if (!right) last_left = w;
    endtask

    task automatic expect_err();
        ev_t e;
        e.is_err = 1'b1;
        e.right  = 1'b0;
        e.data   = '0;
        q1.push_back(e);
        q0.push_back(e);
    endtask

    // adc_mode: 0 = ADC_SDATA must stay low, 1 = check record word, 2 = not checked
    task automatic half(input logic lr, input int nbclk, input logic [N-1:0] word,
                        input int adc_mode);
        for (int i = 0; i < nbclk; i++) begin
            BCLK = 1'b0;
            if (i == 0) LRCLK = lr;
            dac1 = slot_bit(word, i - 1);
            dac0 = slot_bit(word, i);
            repeat (2) @(negedge audio_clk);
            if (adc_mode == 1) begin
                chk($sformatf("i2s adc rise %0d", i), N'(adc_sd1),
                    N'(slot_bit(lr ? r_adc1 : l_adc1, i - 1)));
                chk($sformatf("lj adc rise %0d", i), N'(adc_sd0), N'(slot_bit(adc0, i)));
            end else if (adc_mode == 0) begin
                chk($sformatf("i2s adc idle rise %0d", i), N'(adc_sd1), '0);
                chk($sformatf("lj adc idle rise %0d", i), N'(adc_sd0), '0);
            end
            BCLK = 1'b1;
            repeat (2) @(negedge audio_clk);
        end
    endtask

    always @(negedge audio_clk) begin
        if (!reset && (valid1 || ferr1)) begin
            if (q1.size() == 0) begin
                chk("i2s spurious event", N'({valid1, ferr1}), '0);
            end else begin
                e1 = q1.pop_front();
                chk("i2s event kind", N'({ferr1, valid1}), N'({e1.is_err, !e1.is_err}));
                if (!e1.is_err) begin
                    chk("i2s channel", N'(isr1), N'(e1.right));
                    chk("i2s word", isr1 ? r_dac1 : l_dac1, e1.data);
                end
            end
        end
    end

    always @(negedge audio_clk) begin
        if (!reset && (valid0 || ferr0)) begin
            if (q0.size() == 0) begin
                chk("lj spurious event", N'({valid0, ferr0}), '0);
            end else begin
                e0 = q0.pop_front();
                chk("lj event kind", N'({ferr0, valid0}), N'({e0.is_err, !e0.is_err}));
                if (!e0.is_err) begin
                    chk("lj channel", N'(isr0), N'(e0.right));
                    chk("lj word", isr0 ? r_dac0 : l_dac0, e0.data);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge audio_clk);
        reset = 1'b0;
        @(negedge audio_clk);
        chk("i2s reset flags", N'({adc_sd1, valid1, isr1, ferr1, lock1}), '0);
        chk("i2s reset left", l_dac1, '0);
        chk("i2s reset right", r_dac1, '0);
        chk("lj reset flags", N'({adc_sd0, valid0, isr0, ferr0, lock0}), '0);
        chk("lj reset left", l_dac0, '0);
        chk("lj reset right", r_dac0, '0);

        // BCLK running, LRCLK held low: no lock, no output
        half(1'b0, 16, 24'hFFFFFF, 0);
        chk("i2s unlocked", N'(lock1), '0);
        chk("lj unlocked", N'(lock0), '0);

        expect_word(1'b1, 24'h0F1E2D); half(1'b1, 32, 24'h0F1E2D, 2);
        chk("i2s locked", N'(lock1), N'(1'b1));
        expect_word(1'b0, 24'hA5C3F0); half(1'b0, 32, 24'hA5C3F0, 1);
        expect_word(1'b1, 24'h0F1E2D); half(1'b1, 32, 24'h0F1E2D, 1);

        // short left half-frame
        expect_err();                  half(1'b0, 10, 24'h3C3C3C, 1);
        expect_word(1'b1, 24'h55AA55); half(1'b1, 32, 24'h55AA55, 1);
        chk("i2s left held after short frame", l_dac1, last_left);
        chk("lj left held after short frame", l_dac0, last_left);
        expect_word(1'b0, 24'h123456); half(1'b0, 32, 24'h123456, 1);
        expect_word(1'b1, 24'h123456); half(1'b1, 32, 24'h123456, 1);

        // reset in the middle of a left word
        half(1'b0, 12, 24'hABCDEF, 1);
        BCLK  = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge audio_clk);
        chk("i2s mid reset flags", N'({adc_sd1, valid1, isr1, ferr1, lock1}), '0);
        chk("i2s mid reset words", l_dac1 | r_dac1, '0);
        chk("lj mid reset flags", N'({adc_sd0, valid0, isr0, ferr0, lock0}), '0);
        chk("lj mid reset words", l_dac0 | r_dac0, '0);
        reset = 1'b0;
        half(1'b0, 20, 24'hABCDEF, 0);
        chk("i2s unlocked after reset", N'(lock1), '0);
        chk("lj unlocked after reset", N'(lock0), '0);
        expect_word(1'b1, 24'h0F1E2D); half(1'b1, 32, 24'h0F1E2D, 2);
        expect_word(1'b0, 24'hA5C3F0); half(1'b0, 32, 24'hA5C3F0, 1);

        repeat (20) @(negedge audio_clk);
        chk("i2s events outstanding", N'(q1.size()), '0);
        chk("lj events outstanding", N'(q0.size()), '0);
        chk("i2s final right", r_dac1, 24'h0F1E2D);
        chk("lj final left", l_dac0, 24'hA5C3F0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
